// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared constants for the bit-serial adder controller.
//               FSM state encodings and the default operand width.
// Revision    : 1.0  initial release
// ============================================================================
package serial_add_pkg;

    // Default operand/result width of the serial adder.
    localparam int DEFAULT_WIDTH = 8;

    // Controller state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage : serial_add_pkg
`default_nettype wire

// File: rtl/fad_cell.sv
`default_nettype none
// ============================================================================
// Module      : fad_cell
// Description : Single-bit full adder, the shared datapath cell of the
//               bit-serial adder.
// Ports       : a, b    - operand bits
//               cin     - carry in
//               sum     - sum bit
//               cout    - carry out
// Revision    : 1.0  initial release
// ============================================================================
module fad_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic w_p;

    assign w_p  = a ^ b;
    assign sum  = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);

endmodule : fad_cell
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial adder controller. Reuses one fad_cell across all
//               WIDTH bit positions, LSB first, one bit per clock, with a
//               start/busy/done handshake.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               start           - request, sampled only in IDLE
//               op_a, op_b, cin - operands, captured on the accepting edge
//               busy            - high in RUN and DONE
//               done            - one-cycle pulse, result/cout valid from here
//               result, cout    - sum and carry-out, held until next accept
//               ovf             - signed overflow (only with SERIAL_ADD_OVF_EN)
// Config      : define SERIAL_ADD_OVF_EN to add the ovf output.
// Revision    : 1.0  initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Counter value at which the MSB is processed.
    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             w_sum;
    logic             w_cout;
    logic             w_last;

    assign w_last = (r_cnt == c_last_idx);

    // ------------------------------------------------------------------
    // Shared full-adder cell
    // ------------------------------------------------------------------
    fad_cell u_fad_cell (
        .a    (r_opa[0]),
        .b    (r_opb[0]),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_RUN:  busy = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand shifters, carry, result shifter, bit counter.
    // The sum bit enters at the result MSB so that after WIDTH shifts
    // bit 0 of the sum has reached result[0].
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_opa   <= op_a;
                        r_opb   <= op_b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_result <= {w_sum, r_result[WIDTH-1:1]};
                    r_carry  <= w_cout;
                    r_opa    <= r_opa >> 1;
                    r_opb    <= r_opb >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    // Carry register stays untouched from the last bit until the next
    // accept, so it doubles as the held carry-out.
    assign cout   = r_carry;

`ifdef SERIAL_ADD_OVF_EN
    // Carry into the MSB, captured on the edge that processes the MSB.
    logic r_cmsb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmsb <= 1'b0;
        end else if ((r_state == ST_RUN) && w_last) begin
            r_cmsb <= r_carry;
        end
    end

    assign ovf = r_cmsb ^ r_carry;
`endif

endmodule : serial_add_ctrl
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Self-checking bench for serial_add_ctrl (WIDTH=8). Expected
//               sums are queued at issue time; a monitor pops and compares
//               on every done pulse.
// Revision    : 1.0  initial release
// ============================================================================
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             co;
        logic             ov;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    exp_t q[$];
    exp_t mon_e;
    logic mon_ov;
    int   vectors    = 0;
    int   miscompares = 0;
    int   done_cnt   = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    // Reference: unsigned sum plus signed overflow from operand/sum signs.
    function automatic exp_t ref_add(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] s;
        exp_t       e;
        s     = {1'b0, a} + {1'b0, b} + {8'd0, c};
        e.res = s[7:0];
        e.co  = s[8];
        e.ov  = (a[7] == b[7]) && (s[7] != a[7]);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse consumes one queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_done result=%0h cout=%0b required=no_done", result, cout);
            end else begin
                mon_e = q.pop_front();
`ifdef SERIAL_ADD_OVF_EN
                mon_ov = ovf;
`else
                mon_ov = mon_e.ov;
`endif
                if (result !== mon_e.res || cout !== mon_e.co || mon_ov !== mon_e.ov) begin
                    miscompares++;
                    $display("FAIL sum actual res=%0h cout=%0b ovf=%0b required res=%0h cout=%0b ovf=%0b",
                             result, cout, mon_ov, mon_e.res, mon_e.co, mon_e.ov);
                end
            end
        end
    end

    // Called at a negedge: waits for IDLE, presents one request for one edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c, input bit push);
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        if (push) q.push_back(ref_add(a, b, c));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge after the accepting edge; returns edges to done
    // and the number of busy cycles including the done cycle.
    task automatic wait_done(output int n, output int bc);
        n  = 0;
        bc = 0;
        while (!done && n < 40) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
        if (busy) bc++;
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic add(input logic [7:0] a, input logic [7:0] b, input logic c);
        int n, bc;
        issue(a, b, c, 1'b1);
        wait_done(n, bc);
        @(negedge clk);
    endtask

    initial begin
        int n, bc, dc0;
        bit seen_low;
        logic [7:0] vals [12];
        vals = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81,
                 8'hFE, 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0};

        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout",   32'(cout),   32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_ovf",    32'(ovf),    32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Basic add with latency and busy-length checks.
        issue(8'h05, 8'h03, 1'b0, 1'b1);
        wait_done(n, bc);
        chk("done_latency", 32'(n),  32'(WIDTH));
        chk("busy_cycles",  32'(bc), 32'(WIDTH + 1));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
        chk("result_hold", 32'(result), 32'h08);

        // Wrap-around and carry-in only.
        add(8'hFF, 8'h01, 1'b0);
        add(8'h00, 8'h00, 1'b1);

        // Start held high; operands changed mid-RUN must not disturb the
        // running add, and the second accept lands WIDTH+2 edges later.
        op_a = 8'h11; op_b = 8'h22; cin = 1'b0; start = 1'b1;
        q.push_back(ref_add(8'h11, 8'h22, 1'b0));
        @(negedge clk);
        n = 0; seen_low = 1'b0;
        while (n < 40 && !(seen_low && busy)) begin
            @(negedge clk);
            n++;
            if (n == 4) begin
                op_a = 8'hAA;
                q.push_back(ref_add(8'hAA, 8'h22, 1'b0));
            end
            if (!busy) seen_low = 1'b1;
        end
        start = 1'b0;
        chk("restart_interval", 32'(n), 32'(WIDTH + 2));
        wait_done(n, bc);
        @(negedge clk);

        // Reset during RUN at bit 4: no done, all outputs cleared.
        dc0 = done_cnt;
        issue(8'h12, 8'h34, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_busy",   32'(busy),   32'd0);
        chk("midrun_result", 32'(result), 32'd0);
        chk("midrun_cout",   32'(cout),   32'd0);
        chk("midrun_done",   32'(done),   32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("no_done_after_abort", 32'(done_cnt), 32'(dc0));
        add(8'h10, 8'h20, 1'b0);

        // rst and start together: rst wins.
        rst = 1'b1; start = 1'b1; op_a = 8'h01; op_b = 8'h01;
        @(negedge clk);
        chk("rst_beats_start", 32'(busy), 32'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("still_idle", 32'(busy), 32'd0);

        // Signed-overflow corners.
        add(8'h7F, 8'h01, 1'b0);
        add(8'h80, 8'h80, 1'b0);
        add(8'hFF, 8'h01, 1'b0);

        // Sweep over boundary-heavy operand values.
        foreach (vals[i]) begin
            foreach (vals[j]) begin
                for (int c = 0; c < 2; c++) begin
                    add(vals[i], vals[j], c[0]);
                end
            end
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_serial_add_ctrl
`default_nettype wire
